// File: rtl/sram_controller.sv
// MEM-stage data-memory responder. Each 32-bit word request is served from a
// 16-bit asynchronous SRAM as two halfword phases, and `ready` is held low while busy.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  localparam int unsigned CntW    = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned IdxW    = 17;
  localparam int unsigned HalfW   = 16;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic            is_wr;
    logic [IdxW-1:0] idx;
    logic [31:0]     wdata;
  } req_t;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [17:0]      sram_addr_q, sram_addr_d;
  logic             we_n_q, we_n_d;
  logic             oe_n_q, oe_n_d;
  logic             dq_en_q, dq_en_d;
  logic [HalfW-1:0] dq_out_q, dq_out_d;

  logic             req_c;
  logic [18:0]      byte_off;
  logic [IdxW-1:0]  new_idx;
  logic             unused_bits;

  // Word index relative to the data-memory base; wraps modulo 2^17 words.
  assign byte_off    = addr[18:0] - BASE_ADDR[18:0];
  assign new_idx     = byte_off[18:2];
  assign unused_bits = ^{addr[31:19], byte_off[1:0]};

  assign req_c = wr_en | rd_en;
  assign ready = ~req_c | (state_q == DONE);

  // Next state, read capture and next value of every SRAM pin.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    dq_en_d     = 1'b0;
    dq_out_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          req_d.is_wr = wr_en;
          req_d.idx   = new_idx;
          req_d.wdata = wdata;
          state_d     = LOW;
          cnt_d       = '0;
        end
      end
      LOW: begin
        if (cnt_q == CntLast) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (!req_q.is_wr) rdata_d = {rdata_q[31:16], SRAM_DQ};
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      HIGH: begin
        if (cnt_q == CntLast) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!req_q.is_wr) rdata_d = {SRAM_DQ, rdata_q[15:0]};
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pins are registered, so they are derived from the state being entered.
    if (state_d == LOW || state_d == HIGH) begin
      sram_addr_d = {req_d.idx, (state_d == HIGH)};
      if (req_d.is_wr) begin
        dq_en_d  = 1'b1;
        dq_out_d = (state_d == HIGH) ? req_d.wdata[31:16] : req_d.wdata[15:0];
        we_n_d   = (cnt_d == CntLast);
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_en_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_en_q     <= dq_en_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign rdata     = rdata_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_DQ   = dq_en_q ? dq_out_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: asynchronous SRAM device model plus a word-level
// memory/rdata reference model, directed cases then randomized requests.
module tb_sram_controller;

  localparam int unsigned W    = 3;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          LAST = 2 * W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        we_n, oe_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram [0:262143];
  logic [31:0] exp_mem [int];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .SRAM_ADDR(sram_addr),
    .SRAM_DQ(sram_dq), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n)
  );

  function automatic logic [15:0] pat(input int i);
    return 16'((i * 40503) ^ 23130);
  endfunction

  // Asynchronous SRAM device: drives DQ on read, latches DQ while WE_N is low.
  assign sram_dq = (!oe_n && we_n) ? sram[sram_addr] : 16'hzzzz;

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = pat(i);
    forever begin
      @(posedge clk);
      if (!we_n) sram[sram_addr] <= sram_dq;
    end
  end

  function automatic logic [16:0] idx_of(input logic [31:0] a);
    return 17'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] model_word(input logic [16:0] ix);
    int h;
    h = 2 * int'(ix);
    if (exp_mem.exists(int'(ix))) return exp_mem[int'(ix)];
    return {pat(h + 1), pat(h)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_check(input string tag);
    check_eq({tag, "_ready"}, 32'(ready), 32'd1);
    check_eq({tag, "_we_n"}, 32'(we_n), 32'd1);
    check_eq({tag, "_oe_n"}, 32'(oe_n), 32'd1);
  endtask

  // op: 0 read, 1 write, 2 both (write wins). chain keeps the request asserted through DONE.
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] wd, input bit chain);
    logic [16:0] ix;
    bit          is_wr;
    bit          in_phase;
    bit          hi;
    int          p;
    ix    = idx_of(a);
    is_wr = (op != 0);
    @(negedge clk);
    wr_en = is_wr;
    rd_en = (op != 1);
    addr  = a;
    wdata = wd;
    #1 check_eq("ready_c0", 32'(ready), 32'd0);
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      in_phase = (c <= 2 * W);
      hi       = (c > W);
      p        = (c - 1) % W;
      check_eq("ready", 32'(ready), 32'(c == LAST));
      check_eq("we_n", 32'(we_n), 32'(!(in_phase && is_wr && p < W - 1)));
      check_eq("oe_n", 32'(oe_n), 32'(!(in_phase && !is_wr)));
      if (in_phase) check_eq("sram_addr", 32'(sram_addr), 32'({ix, hi}));
      if (c == LAST) begin
        if (is_wr) exp_mem[int'(ix)] = wd;
        else exp_rdata = model_word(ix);
        check_eq("rdata", rdata, exp_rdata);
        if (!chain) begin
          wr_en = 1'b0;
          rd_en = 1'b0;
        end
      end
    end
    if (is_wr) check_eq("sram_word", {sram[{ix, 1'b1}], sram[{ix, 1'b0}]}, wd);
  endtask

  int          r_op;
  int          r_gap;
  bit          r_chain;
  logic [31:0] r_addr;
  logic [31:0] r_wd;

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    idle_check("in_reset");
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_addr", 32'(sram_addr), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    idle_check("idle");
    check_eq("idle_rdata", rdata, 32'd0);

    // Directed cases.
    do_op(1, 32'd1032, 32'hDEADBEEF, 1'b0);
    check_eq("sram4", 32'(sram[4]), 32'h0000BEEF);
    check_eq("sram5", 32'(sram[5]), 32'h0000DEAD);
    do_op(0, 32'd1032, 32'd0, 1'b0);
    do_op(1, 32'd1024, 32'h12345678, 1'b1);
    do_op(0, 32'd1024, 32'd0, 1'b0);
    do_op(2, 32'd1028, 32'hCAFEF00D, 1'b0);
    check_eq("both_rdata", rdata, 32'h12345678);
    check_eq("sram2", 32'(sram[2]), 32'h0000F00D);
    check_eq("sram3", 32'(sram[3]), 32'h0000CAFE);

    // Reset in the middle of a write.
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; addr = BASE + 32'd400; wdata = 32'hA5A55A5A;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_we_n", 32'(we_n), 32'd0);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_we_n", 32'(we_n), 32'd1);
    check_eq("mid_rst_oe_n", 32'(oe_n), 32'd1);
    check_eq("mid_rst_rdata", rdata, 32'd0);
    check_eq("mid_rst_addr", 32'(sram_addr), 32'd0);
    wr_en = 1'b0;
    #1 check_eq("mid_rst_ready", 32'(ready), 32'd1);
    exp_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    idle_check("post_rst");
    do_op(0, BASE + 32'd20, 32'd0, 1'b0);

    // Randomized requests, including addresses that wrap below the base.
    for (int n = 0; n < 40; n++) begin
      r_op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) r_addr = BASE - 32'(4 * $urandom_range(1, 4));
      else r_addr = BASE + 32'(4 * $urandom_range(0, 15));
      r_addr[1:0] = 2'($urandom);
      r_wd    = $urandom;
      r_chain = (n != 39) && ($urandom_range(0, 1) == 1);
      do_op(r_op, r_addr, r_wd, r_chain);
      if (!r_chain) begin
        r_gap = int'($urandom_range(0, 2));
        for (int g = 0; g < r_gap; g++) begin
          @(negedge clk);
          idle_check("gap");
        end
      end
    end

    @(negedge clk);
    idle_check("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Data-memory responder for the MEM stage of the ARM pipeline. Accepts single-word read and write requests, each with a 32-bit address, and serves them from an external 16-bit asynchronous SRAM as two halfword accesses. While a request is in progress it drives `ready` low, which the pipeline uses as a freeze for all stages. Sits between the MEM stage and the off-chip SRAM pins.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: first byte address of data memory; subtracted from `addr` before mapping to the SRAM.
- `WAIT_CYCLES`, default 3: cycles spent per halfword phase. Must be at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  word write request from the MEM stage.
- `rd_en`  in  1  word read request from the MEM stage.
- `addr`  in  32  byte address; bits [1:0] are ignored.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; registered.
- `ready`  out  1  low while a request is being serviced (pipeline freeze); combinational.
- `SRAM_ADDR`  out  18  halfword address to the SRAM.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_WE_N`  out  1  SRAM write enable, active-low.
- `SRAM_OE_N`  out  1  SRAM output enable, active-low.

## Operation
- Address map: `idx = (addr - BASE_ADDR)[18:2]` (17 bits; out-of-range addresses wrap modulo 2^17 words).
  - Low halfword at `{idx,1'b0}`, high halfword at `{idx,1'b1}`.
- FSM states: IDLE, LOW, HIGH, DONE. A phase counter `cnt` runs from 0 to WAIT_CYCLES-1.
  - IDLE: if `wr_en|rd_en`, latch the operation type (write wins if both are asserted), `addr`, and `wdata`; go to LOW with cnt=0.
  - LOW: `SRAM_ADDR = {idx,0}`. When cnt=WAIT_CYCLES-1, go to HIGH with cnt=0. Otherwise increment cnt.
  - HIGH: `SRAM_ADDR = {idx,1}`. When cnt=WAIT_CYCLES-1, go to DONE.
  - DONE: stay one cycle, then go to IDLE unconditionally.
- `ready = ~(wr_en|rd_en) | (state==DONE)`.
- Write phases:
  - `SRAM_DQ` is driven with `wdata[15:0]` in LOW and `wdata[31:16]` in HIGH.
  - `SRAM_WE_N` is 0 for cnt < WAIT_CYCLES-1 and 1 on the last cycle of each phase (data/address hold).
  - `SRAM_OE_N` = 1.
- Read phases:
  - `SRAM_OE_N` = 0, `SRAM_WE_N` = 1, `SRAM_DQ` is high-Z.
  - `rdata[15:0]` is captured from DQ at the edge ending LOW; `rdata[31:16]` at the edge ending HIGH.
- Outside write phases, `SRAM_DQ` is high-Z. In IDLE and DONE, `SRAM_WE_N` = `SRAM_OE_N` = 1.
- `rdata` holds its value until the next read overwrites it. Writes do not modify `rdata`.
- Request inputs that change or drop mid-operation are ignored. The latched operation completes.

## Timing
- Reset (asynchronous, `rst`=0):
  - state=IDLE, cnt=0, `rdata`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ` high-Z.
  - `ready` follows its equation and is 1 with no request.
  - A reset mid-operation abandons the access. A partial SRAM write may remain.
- Request first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W, HIGH occupies cycles W+1..2W, DONE is cycle 2W+1. W = WAIT_CYCLES.
  - `ready`=0 for cycles 0..2W and 1 in cycle 2W+1. With W=3: low for 7 cycles, high at cycle 7.
- Read data is valid in `rdata` from cycle 2W+1 onward. The MEM/WB register captures it at the end of the DONE cycle.
- Back-to-back requests: DONE always returns to IDLE. A request still present in IDLE at cycle 2W+2 starts a new access, with `ready`=0 again in that cycle. Throughput is one word per 2W+2 cycles.
- No request in IDLE: `ready`=1 and the state stays IDLE.

## Test plan
- Idle after reset, no requests: `ready`=1, `SRAM_WE_N`=`SRAM_OE_N`=1, `rdata`=0, DQ high-Z.
- Write 0xDEADBEEF to addr 1032 (W=3):
  - SRAM[4] = 0xBEEF and SRAM[5] = 0xDEAD.
  - `ready` is low for cycles 0..6 and high at cycle 7.
  - `SRAM_WE_N` is low in cycles 1–2 and 4–5.
- Read addr 1032 after that write: `rdata`=0xDEADBEEF in cycle 7, `SRAM_OE_N` low in cycles 1–6.
- Back-to-back write of 0x12345678 to 1024 followed by a read of 1024 with `rd_en` held: the second access starts at cycle 8, and `rdata`=0x12345678 with `ready`=1 at cycle 15.
- `wr_en` and `rd_en` asserted together on addr 1028 with `wdata`=0xCAFEF00D: a write is performed (SRAM[2]=0xF00D, SRAM[3]=0xCAFE) and `rdata` is unchanged.
- Assert `rst`=0 during cycle 2 of a write: FSM returns to IDLE immediately, `SRAM_WE_N`=1, DQ high-Z, `rdata`=0; after release, a new read completes normally in 2W+2 cycles.
